reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports (1..4).
REQ-004 Parameter R0_ZERO, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-005 Parameter SP_IDX, default 29, and SP_INIT, default 32'h0000_1000: index and initial value of the stack-pointer entry.
REQ-006 Ports, clock and reset first, SHALL be:
- clk_in  input  1  CPU clock; all state updates on rising edge.
- rst_n_in  input  1  reset; one clock, synchronous, active-low.
- stall_in  input  1  pipeline stall; freezes read outputs and suppresses writes.
- rd_addr_in  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data_out  output  NUM_RD*DATA_W  packed registered read data; port k at bits [k*DATA_W +: DATA_W].
- wa_we_in  input  1  write port A enable.
- wa_addr_in  input  ADDR_W  write port A address.
- wa_data_in  input  DATA_W  write port A data.
- wb_we_in  input  1  write port B enable.
- wb_addr_in  input  ADDR_W  write port B address.
- wb_data_in  input  DATA_W  write port B data.
- ready_out  output  1  high once initialisation has completed.
- init_idx_out  output  ADDR_W  entry being initialised; 0 when ready.

Function
REQ-007 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-008 INIT: one entry written per cycle, counter 0..DEPTH-1; entry i gets value i, except SP_IDX gets SP_INIT and entry 0 gets 0 when R0_ZERO=1.
REQ-009 The INIT counter SHALL advance regardless of stall_in.
REQ-010 INIT -> RUN on the cycle the counter writes DEPTH-1.
- ready_out goes high on the following edge, DEPTH cycles after rst_n_in deasserts.
REQ-011 In INIT, write ports SHALL be ignored and rd_data_out SHALL be held at 0.
REQ-012 In RUN with stall_in=0, each enabled write port SHALL update its entry at the rising edge.
REQ-013 If both write ports target the same address in one cycle, port B data SHALL win.
REQ-014 When R0_ZERO=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-015 Read latency SHALL be exactly one cycle: rd_data_out at edge N+1 reflects rd_addr_in sampled at edge N.
REQ-016 Reads SHALL be write-first: a read address matching an enabled write in the same cycle returns the new data.
- Port B has priority over port A.
- R0 rule still applies.
REQ-017 With stall_in=1 in RUN:
- rd_data_out SHALL hold its previous value.
- no entry SHALL change.
REQ-018 All read ports SHALL be independent; any ports may read the same address.

Reset
REQ-019 While rst_n_in=0 at a rising edge, the block SHALL set:
- state to INIT;
- counter to 0;
- ready_out, init_idx_out and rd_data_out to 0.
REQ-020 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from entry 0.
- Register contents are fully rewritten before ready_out rises again.

Verification
REQ-021 Release reset, stall_in=1 throughout INIT, DEPTH=32 -> ready_out rises exactly 32 cycles after release; reading addresses 5 and 29 then gives 5 and 32'h1000.
REQ-022 Same cycle: wa writes 7<-32'hAAAA, wb writes 7<-32'h5555, read port 0 address 7 -> next cycle rd_data_out[0] = 32'h5555, and the stored value is 32'h5555.
REQ-023 Write 0<-32'hFFFF_FFFF with R0_ZERO=1, reading address 0 in the same and next cycle -> both return 0.
REQ-024 stall_in=1 with wa writing 3<-32'h1234 and read address changed to 3 -> rd_data_out unchanged, entry 3 still 3; after stall drops, read 3 returns 3.
REQ-025 Assert rst_n_in=0 for one cycle at counter value 12 of INIT -> init_idx_out returns to 0; ready_out rises 32 cycles after the second release.
REQ-026 NUM_RD=4, all ports reading addresses 1,2,1,31 in RUN -> next cycle outputs 1,2,1,31.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read, dual-write register file with self-initialisation.
// Entries are seeded one per cycle after reset, then served with write-first reads.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter bit R0_ZERO = 1'b1,
    parameter int SP_IDX = 29,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_1000)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     stall_in,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_in,
    output logic [NUM_RD*DATA_W-1:0] rd_data_out,
    input  logic                     wa_we_in,
    input  logic [ADDR_W-1:0]        wa_addr_in,
    input  logic [DATA_W-1:0]        wa_data_in,
    input  logic                     wb_we_in,
    input  logic [ADDR_W-1:0]        wb_addr_in,
    input  logic [DATA_W-1:0]        wb_data_in,
    output logic                     ready_out,
    output logic [ADDR_W-1:0]        init_idx_out
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              init_last;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] init_val;

    logic run_upd;
    logic wa_ok;
    logic wb_ok;

    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [DATA_W-1:0] rd_next [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_q;

    assign init_last = (cnt_q == ADDR_W'(DEPTH - 1));

    // Writes only land in RUN, out of reset and when the pipe is not stalled;
    // address 0 is hard-wired when R0_ZERO is set.
    assign run_upd = rst_n_in && (state_q == ST_RUN) && !stall_in;
    assign wa_ok   = run_upd && wa_we_in && !(R0_ZERO && (wa_addr_in == '0));
    assign wb_ok   = run_upd && wb_we_in && !(R0_ZERO && (wb_addr_in == '0));

    // State and init counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk every entry once, ignoring stall, then run forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (init_last) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Seed value for the entry being initialised.
    always_comb begin
        init_val = DATA_W'(cnt_q);
        if (cnt_q == ADDR_W'(SP_IDX)) begin
            init_val = SP_INIT;
        end
        if (R0_ZERO && (cnt_q == '0)) begin
            init_val = '0;
        end
    end

    // Storage update; port B is applied last so it wins a same-address clash.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && (state_q == ST_INIT)) begin
            mem_q[cnt_q] <= init_val;
        end else begin
            if (wa_ok) begin
                mem_q[wa_addr_in] <= wa_data_in;
            end
            if (wb_ok) begin
                mem_q[wb_addr_in] <= wb_data_in;
            end
        end
    end

    // Per-port write-first lookup: B beats A beats storage, R0 beats all.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = rd_addr_in[k*ADDR_W +: ADDR_W];
            rd_next[k] = mem_q[rd_addr[k]];
            if (wa_ok && (wa_addr_in == rd_addr[k])) begin
                rd_next[k] = wa_data_in;
            end
            if (wb_ok && (wb_addr_in == rd_addr[k])) begin
                rd_next[k] = wb_data_in;
            end
            if (R0_ZERO && (rd_addr[k] == '0)) begin
                rd_next[k] = '0;
            end
        end
    end

    // Registered read data: zero in reset/INIT, held while stalled.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rd_q <= '0;
        end else if (state_q == ST_INIT) begin
            rd_q <= '0;
        end else if (!stall_in) begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_q[k*DATA_W +: DATA_W] <= rd_next[k];
            end
        end
    end

    assign rd_data_out  = rd_q;
    assign ready_out    = (state_q == ST_RUN);
    assign init_idx_out = (state_q == ST_INIT) ? cnt_q : '0;

endmodule
